// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: shared types and constants for the TinyALU scheduler slice
package tinyalu_pkg;
  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } operation_t;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} sched_state_t;
  localparam int TIMEOUT_DEF = 32;
  // Undefined encodings 5..7 never reach the ALU and behave like no_op
  function automatic logic is_alu_op(input logic [2:0] op);
    return op inside {add_op, and_op, xor_op, mul_op};
  endfunction
endpackage

// File: rtl/tinyalu_rr_pick.sv
// tinyalu_rr_pick: combinational rotating-priority picker starting at ptr+1
module tinyalu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any_valid
);
  int k;
  // Scan farthest-first so the nearest valid index after ptr is written last and wins
  always_comb begin
    grant = '0;
    idx = '0;
    k = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (req_valid[k]) begin
        grant = NUM_REQ'(1) << k;
        idx = ID_W'(k);
      end
    end
    any_valid = |req_valid;
  end
endmodule

// File: rtl/tinyalu_scheduler.sv
// tinyalu_scheduler: round-robin sharing of one TinyALU between NUM_REQ requesters
module tinyalu_scheduler
  import tinyalu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ*3-1:0] req_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 alu_start,
  output logic [2:0]           alu_op,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  sched_state_t state, state_n;
  logic [ID_W-1:0] ptr, g_idx, id_q;
  logic [NUM_REQ-1:0] grant;
  logic any_valid, hs, timeout, err_q;
  logic [2:0] g_op, op_q;
  logic [7:0] a_q, b_q;
  logic [15:0] res_q;
  logic [WD_W-1:0] wd;
  tinyalu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req_valid(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(g_idx),
    .any_valid(any_valid)
  );
  assign hs = state == IDLE && any_valid;
  assign g_op = req_op[3*int'(g_idx) +: 3];
  assign timeout = wd == WD_W'(TIMEOUT - 1);
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_n;
  always_comb
    state_n = state == IDLE  ? (hs ? (is_alu_op(g_op) ? ISSUE : RESP) : IDLE) :
              state == ISSUE ? ((alu_done || timeout) ? RESP : ISSUE) :
              state == RESP  ? (rsp_ready ? IDLE : RESP) : IDLE;
  // Result/err are preset to 0 at grant so no_op and timeout need no extra path
  always_ff @(posedge clk)
    if (!reset_n) begin
      ptr <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      wd <= '0;
    end else begin
      if (hs) begin
        ptr <= g_idx;
        id_q <= g_idx;
        a_q <= req_a[8*int'(g_idx) +: 8];
        b_q <= req_b[8*int'(g_idx) +: 8];
        op_q <= g_op;
        res_q <= '0;
        err_q <= 1'b0;
      end
      if (state == ISSUE) begin
        wd <= wd + WD_W'(1);
        if (alu_done) res_q <= alu_result;
        else if (timeout) err_q <= 1'b1;
      end
      if (state == RESP && rsp_ready) wd <= '0;
    end
  always_comb begin
    req_ready = state == IDLE ? grant : '0;
    alu_start = state == ISSUE;
    rsp_valid = state == RESP;
  end
  assign rsp_id = id_q;
  assign rsp_result = res_q;
  assign rsp_err = err_q;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
endmodule

// File: tb/tb_tinyalu_scheduler.sv
// tb_tinyalu_scheduler: scoreboard bench with a latency-accurate TinyALU model
module tb_tinyalu_scheduler;
  logic clk = 1'b0, reset_n = 1'b0, rsp_ready = 1'b1, alu_en = 1'b1;
  logic [3:0] req_valid = '0, req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [11:0] req_op = '0;
  logic rsp_valid, rsp_err, alu_start, alu_done;
  logic [1:0] rsp_id, acnt;
  logic [15:0] rsp_result, alu_result;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  typedef struct {logic [1:0] id; logic [15:0] res; logic err;} exp_t;
  exp_t q[$];
  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  tinyalu_scheduler #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  // ALU model: done in the first start cycle for single-cycle ops, third for mul
  always_ff @(posedge clk) acnt <= (alu_start && !alu_done) ? acnt + 2'd1 : 2'd0;
  assign alu_done = alu_en && alu_start && acnt == (alu_op == 3'd4 ? 2'd2 : 2'd0);
  assign alu_result = alu_op == 3'd1 ? 16'(alu_a) + 16'(alu_b) :
                      alu_op == 3'd2 ? {8'h00, alu_a & alu_b} :
                      alu_op == 3'd3 ? {8'h00, alu_a ^ alu_b} :
                      alu_op == 3'd4 ? 16'(alu_a) * 16'(alu_b) : 16'h0000;

  function automatic logic [15:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1: return {8'h00, a} + {8'h00, b};
      3'd2: return {8'h00, a & b};
      3'd3: return {8'h00, a ^ b};
      3'd4: return {8'h00, a} * {8'h00, b};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_op[3*i +: 3] = op;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input int id, output bit ok);
    int n = 0;
    #1;
    while (!req_ready[id] && n < 20) begin
      tick;
      n++;
    end
    ok = req_ready[id];
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL grant_wait id=%0d: req_ready=%b, required bit set", id, req_ready);
    end
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    n_checks++;
    if (q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: response id=%0d with empty scoreboard", name, rsp_id);
      return;
    end
    e = q.pop_front();
    if (rsp_id !== e.id || rsp_result !== e.res || rsp_err !== e.err) begin
      n_errors++;
      $display("FAIL %s: got id=%0d res=%h err=%b, required id=%0d res=%h err=%b",
               name, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
    end
  endtask

  task automatic run_one(input string name, input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input int lat, input int starts, input logic err);
    bit ok;
    int c = 1, s = 0;
    q.push_back('{id: 2'(id), res: err ? 16'h0 : model(op, a, b), err: err});
    set_req(id, a, b, op);
    req_valid[id] = 1'b1;
    wait_ready(id, ok);
    tick;
    req_valid[id] = 1'b0;
    while (!rsp_valid && c < 64) begin
      s += int'(alu_start);
      tick;
      c++;
    end
    n_checks++;
    if (c != lat) begin
      n_errors++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, c, lat);
    end
    n_checks++;
    if (s != starts) begin
      n_errors++;
      $display("FAIL %s_start_cycles: got %0d, required %0d", name, s, starts);
    end
    n_checks++;
    if (alu_start !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_start_in_resp: got %b, required 0", name, alu_start);
    end
    check_rsp(name);
    tick;
  endtask

  task automatic drain(input string name, input int n);
    int got = 0;
    logic [3:0] hs;
    for (int cyc = 0; cyc < 300 && got < n; cyc++) begin
      #1;
      hs = req_valid & req_ready;
      if (rsp_valid) begin
        check_rsp(name);
        got++;
      end
      tick;
      req_valid = req_valid & ~hs;
    end
    n_checks++;
    if (got != n) begin
      n_errors++;
      $display("FAIL %s_count: got %0d responses, required %0d", name, got, n);
    end
  endtask

  task automatic test_reset;
    do_reset;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b id=%0d res=%h err=%b st=%b op=%0d a=%h b=%h, required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b);
    end
    req_valid = 4'b1010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) begin
      n_errors++;
      $display("FAIL reset_pointer_grant: got %b, required 0010", req_ready);
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_single;
    run_one("single_add", 0, 8'hFF, 8'h01, 3'd1, 2, 1, 1'b0);
    run_one("mul_latency", 1, 8'hFE, 8'h03, 3'd4, 4, 3, 1'b0);
    run_one("undef_op", 2, 8'h12, 8'h34, 3'd6, 1, 0, 1'b0);
  endtask

  task automatic test_round_robin;
    do_reset;
    set_req(0, 8'hFF, 8'h01, 3'd1);
    set_req(1, 8'hFE, 8'h03, 3'd4);
    set_req(2, 8'h55, 8'hFF, 3'd2);
    set_req(3, 8'h55, 8'hFF, 3'd3);
    for (int i = 0; i < 4; i++) q.push_back('{id: 2'(i), res: model(req_op[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]), err: 1'b0});
    req_valid = 4'b1111;
    drain("round_robin", 4);
  endtask

  task automatic test_backpressure;
    bit ok;
    rsp_ready = 1'b0;
    q.push_back('{id: 2'd0, res: 16'h0, err: 1'b0});
    set_req(0, 8'h12, 8'h34, 3'd0);
    req_valid[0] = 1'b1;
    wait_ready(0, ok);
    tick;
    req_valid[0] = 1'b0;
    set_req(1, 8'h10, 8'h20, 3'd1);
    req_valid[1] = 1'b1;
    q.push_back('{id: 2'd1, res: 16'h0030, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (!(rsp_valid === 1'b1 && rsp_id === 2'd0 && rsp_result === 16'h0 && rsp_err === 1'b0)) begin
        n_errors++;
        $display("FAIL bp_hold cycle %0d: rv=%b id=%0d res=%h err=%b, required 1/0/0000/0",
                 i, rsp_valid, rsp_id, rsp_result, rsp_err);
      end
      n_checks++;
      if (req_ready !== 4'b0000 || alu_start !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_quiet cycle %0d: req_ready=%b alu_start=%b, required 0000/0", i, req_ready, alu_start);
      end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    check_rsp("bp_noop");
    tick;
    drain("bp_next", 1);
  endtask

  task automatic test_timeout;
    alu_en = 1'b0;
    run_one("timeout", 3, 8'h01, 8'h02, 3'd1, 9, 8, 1'b1);
    alu_en = 1'b1;
    run_one("after_timeout", 0, 8'h40, 8'h02, 3'd1, 2, 1, 1'b0);
  endtask

  task automatic test_reset_mid_mul;
    bit ok, seen = 0;
    set_req(2, 8'hFE, 8'h03, 3'd4);
    req_valid[2] = 1'b1;
    wait_ready(2, ok);
    tick;
    req_valid[2] = 1'b0;
    n_checks++;
    if (alu_start !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_mul_issue: alu_start=%b, required 1", alu_start);
    end
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: rdy=%b rv=%b id=%0d res=%h st=%b op=%0d a=%h b=%h, required all 0",
               req_ready, rsp_valid, rsp_id, rsp_result, alu_start, alu_op, alu_a, alu_b);
    end
    for (int i = 0; i < 6; i++) begin
      seen |= rsp_valid;
      tick;
    end
    n_checks++;
    if (seen) begin
      n_errors++;
      $display("FAIL mid_reset_stale: rsp_valid seen=%b, required 0", seen);
    end
    set_req(0, 8'h03, 8'h04, 3'd3);
    set_req(3, 8'h07, 8'h08, 3'd1);
    q.push_back('{id: 2'd0, res: 16'h0007, err: 1'b0});
    q.push_back('{id: 2'd3, res: 16'h000F, err: 1'b0});
    req_valid = 4'b1001;
    drain("post_reset_order", 2);
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_timeout;
    test_reset_mid_mul;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: %0d left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
